draw_list_master: RTL and testbench

Avalon-MM master that drives the copy engine's register slave, so the NIOS does not have to program every sprite blit itself. It walks a draw list held in on-chip list memory. For each entry it writes copy-engine registers 0..6, then writes execute=1, then polls register 15 until the engine clears it. It sits between the list RAM (read port) and the copy engine wrapper's Avalon slave port; the NIOS only supplies base, count and start.

---
 rtl/draw_list_master_pkg.sv | 48 ++++
 rtl/draw_list_master_if.sv | 29 ++
 rtl/draw_list_master.sv | 179 +++++++++++++++++
 tb/tb_draw_list_master.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_list_master_pkg.sv
`default_nettype none
// ============================================================================
// copy_engine_pkg : copy-engine register map and draw-list master state codes
// Rev 1.0
// ============================================================================
package copy_engine_pkg;

  localparam int CE_DATA_W = 32;
  localparam int CE_ADDR_W = 4;

  localparam logic [3:0] CE_REG_X_START = 4'd0;
  localparam logic [3:0] CE_REG_X_END   = 4'd1;
  localparam logic [3:0] CE_REG_Y_START = 4'd2;
  localparam logic [3:0] CE_REG_Y_END   = 4'd3;
  localparam logic [3:0] CE_REG_SRC     = 4'd4;
  localparam logic [3:0] CE_REG_PALETTE = 4'd5;
  localparam logic [3:0] CE_REG_FLIP    = 4'd6;
  localparam logic [3:0] CE_REG_FRAME   = 4'd14;
  localparam logic [3:0] CE_REG_EXEC    = 4'd15;

  localparam int CE_CMD_WORDS = 7;

  typedef logic [2:0] dlm_state_t;

  localparam dlm_state_t S_IDLE     = 3'd0;
  localparam dlm_state_t S_FETCH    = 3'd1;
  localparam dlm_state_t S_WR       = 3'd2;
  localparam dlm_state_t S_KICK     = 3'd3;
  localparam dlm_state_t S_GAP      = 3'd4;
  localparam dlm_state_t S_POLL     = 3'd5;
  localparam dlm_state_t S_FINISH   = 3'd6;
  localparam dlm_state_t S_ABORT_WR = 3'd7;

  // List word k of a command lands in this copy-engine register.
  function automatic logic [3:0] word_reg(input logic [2:0] k);
    case (k)
      3'd0:    return CE_REG_X_START;
      3'd1:    return CE_REG_X_END;
      3'd2:    return CE_REG_Y_START;
      3'd3:    return CE_REG_Y_END;
      3'd4:    return CE_REG_SRC;
      3'd5:    return CE_REG_PALETTE;
      default: return CE_REG_FLIP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/draw_list_master_if.sv
`default_nettype none
// ============================================================================
// draw_list_master_if : Avalon-MM link between list master and copy engine
// Rev 1.0
// ============================================================================
interface draw_list_master_if;
  import copy_engine_pkg::*;

  logic                 AVM_CS;
  logic                 AVM_READ;
  logic                 AVM_WRITE;
  logic [CE_ADDR_W-1:0] AVM_ADDR;
  logic [3:0]           AVM_BYTE_EN;
  logic [CE_DATA_W-1:0] AVM_WRITEDATA;
  logic [CE_DATA_W-1:0] AVM_READDATA;
  logic                 AVM_WAITREQUEST;

  modport master (
    output AVM_CS, AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA,
    input  AVM_READDATA, AVM_WAITREQUEST
  );

  modport slave (
    input  AVM_CS, AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA,
    output AVM_READDATA, AVM_WAITREQUEST
  );

endinterface
`default_nettype wire

// File: rtl/draw_list_master.sv
`default_nettype none
// ============================================================================
// draw_list_master : walks a draw list and programs/kicks/polls the copy engine
// Rev 1.0
// ============================================================================
module draw_list_master
  import copy_engine_pkg::*;
#(
  parameter int LIST_AW       = 10,
  parameter int COUNT_W       = 8,
  parameter int WORDS_PER_CMD = 8,
  parameter int POLL_GAP      = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LIST_AW-1:0]   list_base,
  input  logic [COUNT_W-1:0]   list_count,
  output logic [LIST_AW-1:0]   cmd_addr,
  input  logic [31:0]          cmd_data,
  draw_list_master_if.master   avm,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [COUNT_W-1:0]   cmds_done
);

  localparam int GAP_W = $clog2(POLL_GAP + 1);

  dlm_state_t         state;
  logic [LIST_AW-1:0] base_q;
  logic [COUNT_W-1:0] count_q;
  logic [2:0]         k;
  logic [GAP_W-1:0]   gap_cnt;
  logic               wr_first;
  logic [31:0]        data_hold;

  logic               accepted;
  logic               last_word;
  logic               last_cmd;
  logic               rd;
  logic               wr;
  logic [3:0]         addr;
  logic [31:0]        wdata;
  logic               unused_rdata;

  assign accepted  = !avm.AVM_WAITREQUEST;
  assign last_word = (k == 3'(CE_CMD_WORDS - 1));
  assign last_cmd  = ((cmds_done + COUNT_W'(1)) == count_q);

  // cmds_done doubles as the command index: both restart at zero and step together.
  assign cmd_addr = base_q + LIST_AW'(cmds_done) * LIST_AW'(WORDS_PER_CMD) + LIST_AW'(k);

  assign unused_rdata = ^avm.AVM_READDATA[31:1];

  always_comb begin
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 4'd0;
    wdata = 32'd0;
    case (state)
      S_WR: begin
        wr    = 1'b1;
        addr  = word_reg(k);
        // Memory data is only guaranteed on the first WR cycle; stalls replay the copy.
        wdata = wr_first ? cmd_data : data_hold;
      end
      S_KICK: begin
        wr    = 1'b1;
        addr  = CE_REG_EXEC;
        wdata = 32'd1;
      end
      S_POLL: begin
        rd    = 1'b1;
        addr  = CE_REG_EXEC;
      end
      S_ABORT_WR: begin
        wr    = 1'b1;
        addr  = CE_REG_EXEC;
      end
      default: ;
    endcase
  end

  assign avm.AVM_CS        = rd | wr;
  assign avm.AVM_READ      = rd;
  assign avm.AVM_WRITE     = wr;
  assign avm.AVM_ADDR      = addr;
  assign avm.AVM_BYTE_EN   = {4{rd | wr}};
  assign avm.AVM_WRITEDATA = wdata;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      k         <= 3'd0;
      gap_cnt   <= '0;
      wr_first  <= 1'b0;
      data_hold <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cmds_done <= '0;
    end else begin
      done     <= 1'b0;
      wr_first <= (state == S_FETCH);
      if (state == S_WR && wr_first) data_hold <= cmd_data;

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= list_base;
            count_q   <= list_count;
            cmds_done <= '0;
            k         <= 3'd0;
            busy      <= 1'b1;
            aborted   <= 1'b0;
            state     <= (list_count == '0) ? S_FINISH : S_FETCH;
          end
        end
        S_FETCH: state <= abort ? S_ABORT_WR : S_WR;
        S_WR: begin
          if (accepted) begin
            if (abort) state <= S_ABORT_WR;
            else if (last_word) state <= S_KICK;
            else begin
              k     <= k + 3'd1;
              state <= S_FETCH;
            end
          end
        end
        S_KICK: begin
          if (accepted) begin
            gap_cnt <= '0;
            state   <= abort ? S_ABORT_WR : S_GAP;
          end
        end
        S_GAP: begin
          if (abort) state <= S_ABORT_WR;
          else if (gap_cnt == GAP_W'(POLL_GAP - 1)) state <= S_POLL;
          else gap_cnt <= gap_cnt + GAP_W'(1);
        end
        S_POLL: begin
          if (accepted) begin
            // An engine that reports idle on this read has finished the command, abort or not.
            if (!avm.AVM_READDATA[0]) begin
              cmds_done <= cmds_done + COUNT_W'(1);
              k         <= 3'd0;
            end
            if (abort) state <= S_ABORT_WR;
            else if (avm.AVM_READDATA[0]) begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end else state <= last_cmd ? S_FINISH : S_FETCH;
          end
        end
        S_FINISH: begin
          done    <= 1'b1;
          aborted <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        S_ABORT_WR: begin
          if (accepted) begin
            done    <= 1'b1;
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_list_master.sv
`default_nettype none
// ============================================================================
// tb_draw_list_master : directed self-checking bench with a copy-engine slave model
// Rev 1.0
// ============================================================================
module tb_draw_list_master;
  import copy_engine_pkg::*;

  localparam int LIST_AW     = 10;
  localparam int COUNT_W     = 8;
  localparam int EXEC_CYCLES = 30;
  localparam logic [31:0] WORDS1 [7] = '{32'd10, 32'd42, 32'd20, 32'd52, 32'h1234, 32'd2, 32'd1};

  logic               CLK = 1'b0;
  logic               RESET = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [LIST_AW-1:0] list_base = '0;
  logic [COUNT_W-1:0] list_count = '0;
  logic [LIST_AW-1:0] cmd_addr;
  logic [31:0]        cmd_data;
  logic               busy, done, aborted;
  logic [COUNT_W-1:0] cmds_done;

  int errors = 0;
  int checks = 0;

  draw_list_master_if bus();

  draw_list_master #(
    .LIST_AW(LIST_AW), .COUNT_W(COUNT_W), .WORDS_PER_CMD(8), .POLL_GAP(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
    .list_base(list_base), .list_count(list_count),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .avm(bus),
    .busy(busy), .done(done), .aborted(aborted), .cmds_done(cmds_done)
  );

  always #5 CLK = ~CLK;

  // List RAM: synchronous read, one cycle latency.
  logic [31:0] mem [0:1023];
  always @(posedge CLK) cmd_data <= mem[cmd_addr];

  // Copy-engine slave model.
  logic [31:0] regs [0:15];
  int exec_timer = 0;
  int poll_cnt = 0, kick_cnt = 0, stall_total = 0, stall_seen = 0;
  int proto_err = 0, bad_reg = 0, stab_err = 0;
  int stall_addr = 0, stall_len = 0;
  logic [3:0]  log_addr [$];
  logic [31:0] log_data [$];
  logic        prev_wait = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;
  logic [3:0]  prev_addr = 4'd0;
  logic [31:0] prev_wdata = 32'd0;

  assign bus.AVM_WAITREQUEST = bus.AVM_WRITE && (int'(bus.AVM_ADDR) == stall_addr) && (stall_seen < stall_len);
  assign bus.AVM_READDATA = !bus.AVM_READ ? 32'd0 :
                            (bus.AVM_ADDR == CE_REG_EXEC) ? {31'd0, exec_timer != 0} : regs[bus.AVM_ADDR];

  always @(posedge CLK) begin
    if (RESET) begin
      if ((bus.AVM_CS !== (bus.AVM_READ | bus.AVM_WRITE)) || (bus.AVM_BYTE_EN !== {4{bus.AVM_CS}}))
        proto_err <= proto_err + 1;
      if (prev_wait && (bus.AVM_ADDR !== prev_addr || bus.AVM_WRITEDATA !== prev_wdata ||
                        bus.AVM_WRITE !== prev_wr || bus.AVM_READ !== prev_rd))
        stab_err <= stab_err + 1;
      if (bus.AVM_CS && !bus.AVM_WAITREQUEST) begin
        if (bus.AVM_ADDR > CE_REG_FLIP && bus.AVM_ADDR <= CE_REG_FRAME) bad_reg <= bad_reg + 1;
        if (bus.AVM_READ) poll_cnt <= poll_cnt + 1;
      end
    end
    prev_wait  <= bus.AVM_CS && bus.AVM_WAITREQUEST;
    prev_addr  <= bus.AVM_ADDR;
    prev_wdata <= bus.AVM_WRITEDATA;
    prev_wr    <= bus.AVM_WRITE;
    prev_rd    <= bus.AVM_READ;
    if (!busy) stall_seen <= 0;
    else if (bus.AVM_WAITREQUEST) begin
      stall_seen  <= stall_seen + 1;
      stall_total <= stall_total + 1;
    end
    if (bus.AVM_WRITE && !bus.AVM_WAITREQUEST) begin
      log_addr.push_back(bus.AVM_ADDR);
      log_data.push_back(bus.AVM_WRITEDATA);
      regs[bus.AVM_ADDR] <= bus.AVM_WRITEDATA;
      if (bus.AVM_ADDR == CE_REG_EXEC) begin
        exec_timer <= bus.AVM_WRITEDATA[0] ? EXEC_CYCLES : 0;
        if (bus.AVM_WRITEDATA[0]) kick_cnt <= kick_cnt + 1;
      end else if (exec_timer > 0) exec_timer <= exec_timer - 1;
    end else if (exec_timer > 0) exec_timer <= exec_timer - 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start(input logic [LIST_AW-1:0] b, input logic [COUNT_W-1:0] c);
    @(negedge CLK);
    list_base  = b;
    list_count = c;
    start      = 1'b1;
    @(negedge CLK);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, done, aborted, cmds_done, cmd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b aborted=%b cmds_done=%0d cmd_addr=%h want all 0",
               busy, done, aborted, cmds_done, cmd_addr);
    end
    checks++;
    if ({bus.AVM_CS, bus.AVM_READ, bus.AVM_WRITE, bus.AVM_BYTE_EN, bus.AVM_ADDR, bus.AVM_WRITEDATA} !== '0) begin
      errors++;
      $display("FAIL reset_avalon: got cs=%b rd=%b wr=%b be=%h addr=%h wdata=%h want all 0", bus.AVM_CS,
               bus.AVM_READ, bus.AVM_WRITE, bus.AVM_BYTE_EN, bus.AVM_ADDR, bus.AVM_WRITEDATA);
    end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single;
    bit ok;
    int n0, p0;
    logic [35:0] got, exp_v;
    for (int j = 0; j < 7; j++) mem[10'h010 + j] = WORDS1[j];
    n0 = log_addr.size();
    p0 = poll_cnt;
    pulse_start(10'h010, 8'd1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done: got no done want done pulse"); end
    checks++;
    if ({busy, aborted, cmds_done} !== {1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL single_status: got busy=%b aborted=%b cmds_done=%0d want 0 0 1", busy, aborted, cmds_done);
    end
    checks++;
    if (log_addr.size() != n0 + 8) begin
      errors++; $display("FAIL single_wr_count: got %0d want 8", log_addr.size() - n0);
    end
    for (int j = 0; j < 8; j++) begin
      got   = 'x;
      if (n0 + j < log_addr.size()) got = {log_addr[n0 + j], log_data[n0 + j]};
      exp_v = (j < 7) ? {4'(j), WORDS1[j]} : {CE_REG_EXEC, 32'd1};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL single_wr%0d: got %h want %h", j, got, exp_v); end
    end
    checks++;
    if (poll_cnt - p0 != 7) begin errors++; $display("FAIL single_polls: got %0d want 7", poll_cnt - p0); end
    @(negedge CLK);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", done); end
  endtask

  task automatic test_stall;
    bit ok;
    int n0, s0;
    logic [35:0] got, exp_v;
    stall_addr = 3;
    stall_len  = 3;
    n0 = log_addr.size();
    s0 = stall_total;
    pulse_start(10'h010, 8'd1);
    wait_done(400, ok);
    checks++;
    if (!ok || cmds_done !== 8'd1 || aborted !== 1'b0) begin
      errors++; $display("FAIL stall_done: got ok=%b cmds_done=%0d aborted=%b want 1 1 0", ok, cmds_done, aborted);
    end
    checks++;
    if (stall_total - s0 != 3) begin errors++; $display("FAIL stall_cycles: got %0d want 3", stall_total - s0); end
    checks++;
    if (log_addr.size() != n0 + 8) begin
      errors++; $display("FAIL stall_wr_count: got %0d want 8", log_addr.size() - n0);
    end
    for (int j = 0; j < 8; j++) begin
      got   = 'x;
      if (n0 + j < log_addr.size()) got = {log_addr[n0 + j], log_data[n0 + j]};
      exp_v = (j < 7) ? {4'(j), WORDS1[j]} : {CE_REG_EXEC, 32'd1};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL stall_wr%0d: got %h want %h", j, got, exp_v); end
    end
    for (int j = 0; j < 7; j++) begin
      checks++;
      if (regs[j] !== WORDS1[j]) begin errors++; $display("FAIL stall_reg%0d: got %h want %h", j, regs[j], WORDS1[j]); end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
    stall_len = 0;
  endtask

  task automatic test_count_zero;
    int n0, p0;
    bit saw_done;
    n0 = log_addr.size();
    p0 = poll_cnt;
    pulse_start(10'h100, 8'd0);
    checks++;
    if ({done, busy} !== 2'b01) begin errors++; $display("FAIL zero_cycle1: got done=%b busy=%b want 0 1", done, busy); end
    @(negedge CLK);
    checks++;
    if ({done, busy, aborted, cmds_done} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL zero_cycle2: got done=%b busy=%b aborted=%b cmds_done=%0d want 1 0 0 0",
               done, busy, aborted, cmds_done);
    end
    checks++;
    if (log_addr.size() != n0 || poll_cnt != p0) begin
      errors++; $display("FAIL zero_avalon: got %0d accesses want 0", log_addr.size() - n0 + poll_cnt - p0);
    end
    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL idle_abort: got activity=1 want 0"); end
  endtask

  task automatic test_wrap;
    bit ok;
    int n0;
    logic [35:0] got, exp_v;
    for (int j = 0; j < 7; j++) begin
      mem[(10'h3FC + j) % 1024]     = 32'h100 + j;
      mem[(10'h3FC + 8 + j) % 1024] = 32'h200 + j;
    end
    n0 = log_addr.size();
    pulse_start(10'h3FC, 8'd2);
    repeat (20) @(negedge CLK);
    pulse_start(10'h000, 8'd0);
    wait_done(800, ok);
    checks++;
    if (!ok || cmds_done !== 8'd2 || aborted !== 1'b0) begin
      errors++; $display("FAIL wrap_done: got ok=%b cmds_done=%0d aborted=%b want 1 2 0", ok, cmds_done, aborted);
    end
    checks++;
    if (log_addr.size() != n0 + 16) begin
      errors++; $display("FAIL wrap_wr_count: got %0d want 16", log_addr.size() - n0);
    end
    for (int j = 0; j < 16; j++) begin
      got   = 'x;
      if (n0 + j < log_addr.size()) got = {log_addr[n0 + j], log_data[n0 + j]};
      if (j % 8 == 7) exp_v = {CE_REG_EXEC, 32'd1};
      else exp_v = {4'(j % 8), 32'((j < 8) ? 32'h100 : 32'h200) + 32'(j % 8)};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL wrap_wr%0d: got %h want %h", j, got, exp_v); end
    end
  endtask

  task automatic test_abort;
    bit ok, found;
    int n0, k0;
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 7; j++) mem[10'h040 + c * 8 + j] = 32'h300 + c * 16 + j;
    n0 = log_addr.size();
    k0 = kick_cnt;
    pulse_start(10'h040, 8'd3);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (kick_cnt - k0 >= 2 && bus.AVM_READ) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_poll_seen: got no poll of command 2 want poll"); end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    wait_done(50, ok);
    checks++;
    if (!ok || aborted !== 1'b1 || cmds_done !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_status: got ok=%b aborted=%b cmds_done=%0d busy=%b want 1 1 1 0", ok, aborted, cmds_done, busy);
    end
    checks++;
    if (log_addr.size() != n0 + 17 || log_addr[log_addr.size() - 1] !== CE_REG_EXEC ||
        log_data[log_data.size() - 1] !== 32'd0) begin
      errors++;
      $display("FAIL abort_exec_clear: got %0d writes last %h<=%h want 17 writes last f<=0", log_addr.size() - n0,
               log_addr[log_addr.size() - 1], log_data[log_data.size() - 1]);
    end
    repeat (40) @(negedge CLK);
    checks++;
    if (log_addr.size() != n0 + 17 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: got %0d writes busy=%b want 17 0", log_addr.size() - n0, busy);
    end
  endtask

  task automatic test_reset_mid;
    bit ok, found;
    int n0, k0, n1;
    logic [35:0] got_first, got_last;
    n0 = log_addr.size();
    k0 = kick_cnt;
    pulse_start(10'h010, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.AVM_WRITE && bus.AVM_ADDR == 4'd2) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (!found || {busy, done, aborted, cmds_done, cmd_addr, bus.AVM_CS, bus.AVM_READ, bus.AVM_WRITE,
                   bus.AVM_BYTE_EN, bus.AVM_ADDR, bus.AVM_WRITEDATA} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got found=%b busy=%b cs=%b addr=%h wdata=%h cmd_addr=%h want 1 and all 0",
               found, busy, bus.AVM_CS, bus.AVM_ADDR, bus.AVM_WRITEDATA, cmd_addr);
    end
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (log_addr.size() != n0 + 3 || kick_cnt != k0) begin
      errors++; $display("FAIL midreset_partial: got %0d writes %0d kicks want 3 0", log_addr.size() - n0, kick_cnt - k0);
    end
    n1 = log_addr.size();
    pulse_start(10'h010, 8'd1);
    wait_done(400, ok);
    got_first = 'x;
    got_last  = 'x;
    if (log_addr.size() == n1 + 8) begin
      got_first = {log_addr[n1], log_data[n1]};
      got_last  = {log_addr[n1 + 7], log_data[n1 + 7]};
    end
    checks++;
    if (!ok || cmds_done !== 8'd1 || aborted !== 1'b0 || got_first !== {4'd0, 32'd10} ||
        got_last !== {CE_REG_EXEC, 32'd1}) begin
      errors++;
      $display("FAIL midreset_rerun: got ok=%b cmds_done=%0d first=%h last=%h want 1 1 00000000a f00000001",
               ok, cmds_done, got_first, got_last);
    end
  endtask

  task automatic test_protocol;
    checks++;
    if (proto_err != 0) begin errors++; $display("FAIL proto_cs_be: got %0d violations want 0", proto_err); end
    checks++;
    if (bad_reg != 0) begin errors++; $display("FAIL proto_reg_range: got %0d accesses to 7..14 want 0", bad_reg); end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL proto_stall_stable: got %0d changes want 0", stab_err); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    test_reset();
    test_single();
    test_stall();
    test_count_zero();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
